sync_line_fifo: RTL

SYNC_LINE_FIFO -- requirements
Module: sync_line_fifo

---
 rtl/sync_line_fifo.sv | 124 ++++++++++++
 1 files changed

// File: rtl/sync_line_fifo.sv
// Single-clock FIFO that stores an end-of-line tag with each word. It tracks the number
// of stored words and complete lines, and keeps sticky overflow/underflow flags.
module sync_line_fifo #(
  parameter int DATA_WIDTH       = 8,
  parameter int DEPTH_WIDTH      = 12,
  parameter int ALMOST_FULL_NUM  = 4092,
  parameter int ALMOST_EMPTY_NUM = 4,
  parameter int FWFT             = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   wr_eol,
  output logic                   wr_full,
  output logic                   almost_full,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_eol,
  output logic                   rd_valid,
  output logic                   rd_empty,
  output logic                   almost_empty,
  output logic [DEPTH_WIDTH:0]   water_level,
  output logic [DEPTH_WIDTH:0]   line_count,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clr_err
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0]   FULL_LVL = (DEPTH_WIDTH+1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0]   AF_LVL   = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [DEPTH_WIDTH:0]   AE_LVL   = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);
  localparam logic [DEPTH_WIDTH:0]   LVL_ONE  = (DEPTH_WIDTH+1)'(1);
  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE  = DEPTH_WIDTH'(1);

  logic [DATA_WIDTH:0]    mem [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr;
  logic [DEPTH_WIDTH-1:0] rd_ptr;
  logic [DATA_WIDTH:0]    head;
  logic                   head_eol;
  logic                   wr_acc;
  logic                   rd_acc;
  logic [DEPTH_WIDTH:0]   level_nxt;
  logic [DEPTH_WIDTH:0]   lines_nxt;

  // Acceptance uses the registered flags, so a same-cycle read never frees room for a write.
  assign wr_acc   = wr_en & ~wr_full;
  assign rd_acc   = rd_en & ~rd_empty;
  assign head     = mem[rd_ptr];
  assign head_eol = head[DATA_WIDTH];

  always_comb begin
    level_nxt = water_level;
    lines_nxt = line_count;
    case ({wr_acc, rd_acc})
      2'b10:   level_nxt = water_level + LVL_ONE;
      2'b01:   level_nxt = water_level - LVL_ONE;
      default: ;
    endcase
    case ({wr_acc & wr_eol, rd_acc & head_eol})
      2'b10:   lines_nxt = line_count + LVL_ONE;
      2'b01:   lines_nxt = line_count - LVL_ONE;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      water_level  <= '0;
      line_count   <= '0;
      wr_full      <= 1'b0;
      rd_empty     <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      water_level  <= level_nxt;
      line_count   <= lines_nxt;
      wr_full      <= (level_nxt == FULL_LVL);
      rd_empty     <= (level_nxt == '0);
      almost_full  <= (level_nxt >= AF_LVL);
      almost_empty <= (level_nxt <= AE_LVL);
      // A new error event wins over a simultaneous clear.
      overflow     <= (wr_en & wr_full)  | (overflow  & ~clr_err);
      underflow    <= (rd_en & rd_empty) | (underflow & ~clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem[wr_ptr] <= {wr_eol, wr_data};
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data  = rd_empty ? '0 : head[DATA_WIDTH-1:0];
      assign rd_eol   = ~rd_empty & head_eol;
      assign rd_valid = ~rd_empty;
    end else begin : g_std
      logic [DATA_WIDTH:0] out_q;
      logic                valid_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_q   <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc;
          if (rd_acc) out_q <= head;
        end
      end

      assign rd_data  = out_q[DATA_WIDTH-1:0];
      assign rd_eol   = out_q[DATA_WIDTH];
      assign rd_valid = valid_q;
    end
  endgenerate

endmodule
